// File: rtl/regarb_pkg.sv
// regarb_pkg: shared types, default sizes and the round-robin pick helper
// used by the regfile access arbiter.
//
// Contents:
//   state_t           - arbiter FSM states (IDLE, ACCESS, RESP)
//   DEF_AW / DEF_DW   - default address / data widths
//   DEF_IDLE_RD_ADDR  - default parked read address (decodes to no register)
//   DEF_MAX_ADDR      - default highest legal address for the address check
//   rr_pick()         - first set valid bit at or after ptr, wrapping at num_req
package regarb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEF_AW  = 8;
  localparam int DEF_DW  = 32;
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  localparam logic [7:0] DEF_IDLE_RD_ADDR = 8'hFF;
  localparam logic [7:0] DEF_MAX_ADDR     = 8'h3F;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Searches valid[ptr], valid[ptr+1], ... wrapping at num_req; only the
  // low num_req bits of valid are meaningful.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [IDX_W-1:0]   ptr,
                                       input int unsigned        num_req);
    rr_pick_t    r;
    int unsigned j;
    r.found = 1'b0;
    r.idx   = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      j = (32'(ptr) + k) % num_req;
      if ((k < num_req) && !r.found && valid[j[IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = j[IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/regarb_rr_arbiter.sv
// regarb_rr_arbiter: combinational round-robin pick with a registered
// priority pointer. The pointer moves to one past the granted requester
// only when the grant is actually taken (advance).
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   valid       - per-requester request valid
//   advance     - grant taken this cycle; move the pointer past it
//   found       - at least one requester is valid
//   grant_idx   - index of the picked requester
//   grant_oh    - one-hot form of grant_idx (zero when nothing found)
import regarb_pkg::*;

module regarb_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               advance,
  output logic               found,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] grant_oh
);

  logic [IDX_W-1:0]   rr_ptr;
  logic [MAX_REQ-1:0] valid_pad;
  rr_pick_t           pick;

  always_comb begin
    valid_pad = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      valid_pad[i] = valid[i];
    end
    pick      = rr_pick(valid_pad, rr_ptr, NUM_REQ);
    found     = pick.found;
    grant_idx = pick.idx;
    grant_oh  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = pick.found && (pick.idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance && found) begin
      rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_access_arbiter.sv
// regfile_access_arbiter: shares one regfile write port and one regfile
// read port between NUM_REQ requesters with round-robin arbitration and a
// single access in flight at a time.
//
// Transaction timing: request handshake in cycle N (IDLE), regfile strobe
// in N+1 (ACCESS), response from N+2 (RESP) until accepted.
// rf_rd_addr is parked on IDLE_RD_ADDR except during a read's ACCESS cycle
// so read-clear registers are cleared exactly once per read.
//
// Optional feature: define REGARB_ADDR_CHECK_EN to reject addresses above
// MAX_ADDR (no strobe, rsp_err = 1, rsp_rdata = 0). Without it rsp_err is 0.
//
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   req_valid/req_ready        - per-requester request handshake
//   req_write/addr/wdata/be    - flattened request fields, requester i at [i*W +: W]
//   rsp_valid/rsp_ready        - per-requester response handshake
//   rsp_rdata, rsp_err         - shared response payload
//   rf_wr_en/addr/data/be      - regfile write port (registered)
//   rf_rd_addr, rf_rd_data     - regfile read port (combinational read data)
import regarb_pkg::*;

module regfile_access_arbiter #(
  parameter int             NUM_REQ      = 2,
  parameter int             AW           = DEF_AW,
  parameter int             DW           = DEF_DW,
  parameter logic [AW-1:0]  IDLE_RD_ADDR = AW'(DEF_IDLE_RD_ADDR),
  parameter logic [AW-1:0]  MAX_ADDR     = AW'(DEF_MAX_ADDR)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*AW-1:0]     req_addr,
  input  logic [NUM_REQ*DW-1:0]     req_wdata,
  input  logic [NUM_REQ*(DW/8)-1:0] req_be,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DW-1:0]             rsp_rdata,
  output logic                      rsp_err,
  output logic                      rf_wr_en,
  output logic [AW-1:0]             rf_wr_addr,
  output logic [DW-1:0]             rf_wr_data,
  output logic [DW/8-1:0]           rf_wr_be,
  output logic [AW-1:0]             rf_rd_addr,
  input  logic [DW-1:0]             rf_rd_data
);

  localparam int BW = DW / 8;

  state_t             state;
  logic               found;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic               hs;

  logic               sel_write;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;
  logic [BW-1:0]      sel_be;
  logic               sel_err;

  logic [NUM_REQ-1:0] acc_oh;
  logic               acc_write;
  logic               acc_err;

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  assign hs        = (state == IDLE) && found && rst_n;
  assign req_ready = hs ? grant_oh : '0;

  regarb_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (req_valid),
    .advance   (hs),
    .found     (found),
    .grant_idx (grant_idx),
    .grant_oh  (grant_oh)
  );

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
        sel_be    = req_be[i*BW +: BW];
      end
    end
  end

`ifdef REGARB_ADDR_CHECK_EN
  assign sel_err = (sel_addr > MAX_ADDR);
`else
  logic unused_max_addr;
  assign sel_err         = 1'b0;
  assign unused_max_addr = ^MAX_ADDR;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc_oh     <= '0;
      acc_write  <= 1'b0;
      acc_err    <= 1'b0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      rf_wr_be   <= '0;
      rf_rd_addr <= IDLE_RD_ADDR;
    end else begin
      case (state)
        // Handshake: latch the granted request and set up next cycle's strobe.
        IDLE: begin
          if (hs) begin
            acc_oh    <= grant_oh;
            acc_write <= sel_write;
            acc_err   <= sel_err;
            if (sel_write && !sel_err) begin
              rf_wr_en   <= 1'b1;
              rf_wr_addr <= sel_addr;
              rf_wr_data <= sel_wdata;
              rf_wr_be   <= sel_be;
            end else if (!sel_write && !sel_err) begin
              rf_rd_addr <= sel_addr;
            end
            state <= ACCESS;
          end
        end
        // Strobe cycle: capture read data, drop the strobe, raise the response.
        ACCESS: begin
          rf_wr_en   <= 1'b0;
          rf_rd_addr <= IDLE_RD_ADDR;
          rsp_rdata  <= (acc_write || acc_err) ? '0 : rf_rd_data;
          rsp_err    <= acc_err;
          rsp_valid  <= acc_oh;
          state      <= RESP;
        end
        // Response held stable until the granted requester accepts it.
        RESP: begin
          if (|(rsp_ready & acc_oh)) begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
module tb_regfile_access_arbiter;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_write;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N*BW-1:0]   req_be;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              rf_wr_en;
  logic [AW-1:0]     rf_wr_addr;
  logic [DW-1:0]     rf_wr_data;
  logic [BW-1:0]     rf_wr_be;
  logic [AW-1:0]     rf_rd_addr;
  logic [DW-1:0]     rf_rd_data;

  int n_vec = 0;
  int n_err = 0;

`ifdef REGARB_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  regfile_access_arbiter #(
    .NUM_REQ      (N),
    .AW           (AW),
    .DW           (DW),
    .IDLE_RD_ADDR (8'hFF),
    .MAX_ADDR     (8'h3F)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .rf_wr_be   (rf_wr_be),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] b);
    req_valid[i]           = v;
    req_write[i]           = w;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
    req_be[i*BW +: BW]     = b;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 2'b11;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    rsp_ready  = 2'b11;
    rf_rd_data = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #2;
    n_vec++; if ({req_ready, rsp_valid, rsp_err, rf_wr_en} !== 6'b0) begin n_err++; $display("FAIL reset_ctrl got %b want 0", {req_ready, rsp_valid, rsp_err, rf_wr_en}); end
    n_vec++; if ({rsp_rdata, rf_wr_addr, rf_wr_data, rf_wr_be} !== 76'b0) begin n_err++; $display("FAIL reset_data got %h want 0", {rsp_rdata, rf_wr_addr, rf_wr_data, rf_wr_be}); end
    n_vec++; if (rf_rd_addr !== 8'hFF) begin n_err++; $display("FAIL reset_rd_addr got %h want ff", rf_rd_addr); end
    req_valid = '0;
    rst_n     = 1'b1;
  endtask

  task automatic test_single_write();
    set_req(0, 1'b1, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF);
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL wr_handshake got %b want 01", req_ready); end
    cyc();
    set_req(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    #1;
    n_vec++; if (rf_wr_en !== 1'b1) begin n_err++; $display("FAIL wr_strobe got %b want 1", rf_wr_en); end
    n_vec++; if ({rf_wr_addr, rf_wr_data, rf_wr_be} !== {8'h04, 32'hDEADBEEF, 4'hF}) begin n_err++; $display("FAIL wr_fields got %h/%h/%h want 04/deadbeef/f", rf_wr_addr, rf_wr_data, rf_wr_be); end
    n_vec++; if ({rf_rd_addr, rsp_valid} !== {8'hFF, 2'b00}) begin n_err++; $display("FAIL wr_access_other got rd_addr %h rsp_valid %b want ff/00", rf_rd_addr, rsp_valid); end
    cyc();
    #1;
    n_vec++; if ({rsp_valid, rsp_rdata, rf_wr_en} !== {2'b01, 32'h0, 1'b0}) begin n_err++; $display("FAIL wr_resp got valid %b rdata %h wr_en %b want 01/0/0", rsp_valid, rsp_rdata, rf_wr_en); end
    cyc();
    #1;
    n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL wr_resp_done got %b want 00", rsp_valid); end
  endtask

  task automatic test_single_read();
    set_req(1, 1'b1, 1'b0, 8'h08, 32'h0, 4'h0);
    rf_rd_data = 32'h12345678;
    #1;
    n_vec++; if ({req_ready, rf_rd_addr} !== {2'b10, 8'hFF}) begin n_err++; $display("FAIL rd_handshake got ready %b rd_addr %h want 10/ff", req_ready, rf_rd_addr); end
    cyc();
    set_req(1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    #1;
    n_vec++; if ({rf_rd_addr, rf_wr_en} !== {8'h08, 1'b0}) begin n_err++; $display("FAIL rd_strobe got rd_addr %h wr_en %b want 08/0", rf_rd_addr, rf_wr_en); end
    cyc();
    rf_rd_data = 32'h0BADF00D;
    #1;
    n_vec++; if ({rsp_valid, rsp_rdata, rf_rd_addr} !== {2'b10, 32'h12345678, 8'hFF}) begin n_err++; $display("FAIL rd_resp got %b/%h/%h want 10/12345678/ff", rsp_valid, rsp_rdata, rf_rd_addr); end
    cyc();
    #1;
    n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL rd_resp_done got %b want 00", rsp_valid); end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 8'h01, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 8'h02, 32'h0, 4'h0);
    rsp_ready = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp = (t % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_vec++; if (req_ready !== exp) begin n_err++; $display("FAIL contention_grant%0d got %b want %b", t, req_ready, exp); end
      cyc();
      #1;
      n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL contention_busy%0d got %b want 00", t, req_ready); end
      cyc();
      cyc();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    set_req(0, 1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b1, 8'h11, 32'h77777777, 4'hF);
    rsp_ready  = 2'b00;
    rf_rd_data = 32'hA5A50001;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL bp_handshake got %b want 01", req_ready); end
    cyc();
    req_valid[0] = 1'b0;
    #1;
    n_vec++; if (rf_rd_addr !== 8'h10) begin n_err++; $display("FAIL bp_strobe got %h want 10", rf_rd_addr); end
    cyc();
    for (int i = 0; i < 5; i++) begin
      rf_rd_data = $urandom;
      #1;
      n_vec++; if ({rsp_valid, rsp_rdata} !== {2'b01, 32'hA5A50001}) begin n_err++; $display("FAIL bp_hold%0d got %b/%h want 01/a5a50001", i, rsp_valid, rsp_rdata); end
      n_vec++; if ({req_ready, rf_wr_en, rf_rd_addr} !== {2'b00, 1'b0, 8'hFF}) begin n_err++; $display("FAIL bp_quiet%0d got ready %b wr_en %b rd_addr %h want 00/0/ff", i, req_ready, rf_wr_en, rf_rd_addr); end
      cyc();
    end
    rsp_ready[0] = 1'b1;
    req_valid[1] = 1'b0;
    #1;
    n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL bp_last got %b want 01", rsp_valid); end
    cyc();
    #1;
    n_vec++; if ({rsp_valid, req_ready} !== 4'b0) begin n_err++; $display("FAIL bp_release got valid %b ready %b want 00/00", rsp_valid, req_ready); end
    rsp_ready = 2'b11;
  endtask

  task automatic test_reset_mid_access();
    set_req(0, 1'b1, 1'b1, 8'h20, 32'h55AA55AA, 4'h3);
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mid_handshake got %b want 01", req_ready); end
    cyc();
    set_req(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    #1;
    n_vec++; if (rf_wr_en !== 1'b1) begin n_err++; $display("FAIL mid_strobe got %b want 1", rf_wr_en); end
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++; if ({rf_wr_en, rf_wr_addr, rf_wr_data, rf_wr_be} !== 45'b0) begin n_err++; $display("FAIL mid_async_wr got %b/%h/%h/%h want 0", rf_wr_en, rf_wr_addr, rf_wr_data, rf_wr_be); end
    n_vec++; if ({rf_rd_addr, rsp_valid} !== {8'hFF, 2'b00}) begin n_err++; $display("FAIL mid_async_rd got %h/%b want ff/00", rf_rd_addr, rsp_valid); end
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL mid_no_resp%0d got %b want 00", i, rsp_valid); end
      cyc();
    end
    set_req(0, 1'b1, 1'b0, 8'h01, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 8'h02, 32'h0, 4'h0);
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mid_ptr_reset got %b want 01", req_ready); end
    cyc();
    req_valid = 2'b00;
    cyc();
    cyc();
  endtask

  task automatic test_addr_range();
    logic [AW-1:0] exp_rd;
    logic [DW-1:0] exp_data;
    set_req(0, 1'b1, 1'b0, 8'h40, 32'h0, 4'h0);
    rf_rd_data = 32'hCAFEF00D;
    exp_rd     = CHK ? 8'hFF : 8'h40;
    exp_data   = CHK ? 32'h0 : 32'hCAFEF00D;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL range_rd_handshake got %b want 01", req_ready); end
    cyc();
    req_valid = 2'b00;
    #1;
    n_vec++; if ({rf_rd_addr, rf_wr_en} !== {exp_rd, 1'b0}) begin n_err++; $display("FAIL range_rd_strobe got %h/%b want %h/0", rf_rd_addr, rf_wr_en, exp_rd); end
    cyc();
    #1;
    n_vec++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, CHK, exp_data}) begin n_err++; $display("FAIL range_rd_resp got %b/%b/%h want 01/%b/%h", rsp_valid, rsp_err, rsp_rdata, CHK, exp_data); end
    cyc();
    set_req(1, 1'b1, 1'b1, 8'h41, 32'h01020304, 4'hF);
    #1;
    n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL range_wr_handshake got %b want 10", req_ready); end
    cyc();
    req_valid = 2'b00;
    #1;
    n_vec++; if (rf_wr_en !== !CHK) begin n_err++; $display("FAIL range_wr_strobe got %b want %b", rf_wr_en, !CHK); end
    cyc();
    #1;
    n_vec++; if ({rsp_valid, rsp_err} !== {2'b10, CHK}) begin n_err++; $display("FAIL range_wr_resp got %b/%b want 10/%b", rsp_valid, rsp_err, CHK); end
    cyc();
  endtask

  // Reference: at most one transaction outstanding; phase 0 = free,
  // 1 = strobe cycle, 2 = awaiting response acceptance.
  task automatic test_random();
    int            ph;
    int            ptr;
    int            g;
    int            cidx;
    bit            cw;
    bit            cerr;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cdata;
    logic [BW-1:0] cbe;
    logic [DW-1:0] crd;
    logic [N-1:0]  exp_ready;
    logic          exp_wr;
    logic [AW-1:0] exp_rd;
    logic [N-1:0]  exp_rv;
    ph = 0; ptr = 0; cidx = 0; cw = 0; cerr = 0;
    caddr = '0; cdata = '0; cbe = '0; crd = '0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      for (int i = 0; i < N; i++) begin
        set_req(i, ($urandom_range(0, 2) != 0), $urandom_range(0, 1), 8'($urandom_range(0, 127)), $urandom, 4'($urandom));
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      rf_rd_data = $urandom;
      #1;
      g = -1;
      if (ph == 0) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
        end
      end
      exp_ready = (g >= 0) ? N'(1 << g) : '0;
      exp_wr    = (ph == 1) && cw && !cerr;
      exp_rd    = ((ph == 1) && !cw && !cerr) ? caddr : 8'hFF;
      exp_rv    = (ph == 2) ? N'(1 << cidx) : '0;
      n_vec++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL rand_ready c%0d got %b want %b", c, req_ready, exp_ready); end
      n_vec++; if ({rf_wr_en, rf_rd_addr} !== {exp_wr, exp_rd}) begin n_err++; $display("FAIL rand_strobe c%0d got %b/%h want %b/%h", c, rf_wr_en, rf_rd_addr, exp_wr, exp_rd); end
      n_vec++; if (rsp_valid !== exp_rv) begin n_err++; $display("FAIL rand_rsp_valid c%0d got %b want %b", c, rsp_valid, exp_rv); end
      if (exp_wr) begin
        n_vec++; if ({rf_wr_addr, rf_wr_data, rf_wr_be} !== {caddr, cdata, cbe}) begin n_err++; $display("FAIL rand_wr_fields c%0d got %h/%h/%h want %h/%h/%h", c, rf_wr_addr, rf_wr_data, rf_wr_be, caddr, cdata, cbe); end
      end
      if (ph == 2) begin
        n_vec++; if ({rsp_rdata, rsp_err} !== {crd, cerr}) begin n_err++; $display("FAIL rand_rsp_data c%0d got %h/%b want %h/%b", c, rsp_rdata, rsp_err, crd, cerr); end
      end
      if (ph == 1) begin
        crd = (cw || cerr) ? '0 : rf_rd_data;
        ph  = 2;
      end else if (ph == 2) begin
        if (rsp_ready[cidx]) ph = 0;
      end else if (g >= 0) begin
        cidx  = g;
        cw    = req_write[g];
        caddr = req_addr[g*AW +: AW];
        cdata = req_wdata[g*DW +: DW];
        cbe   = req_be[g*BW +: BW];
        cerr  = CHK && (caddr > 8'h3F);
        ptr   = (g + 1) % N;
        ph    = 1;
      end
    end
    req_valid = '0;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    rsp_ready  = '0;
    rf_rd_data = '0;
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_backpressure();
    test_reset_mid_access();
    test_addr_range();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
